taxi_axil_rd_timeout: RTL and testbench

AXI4-lite read-channel watchdog inserted on one master port of the AXI-lite read crossbar, between the crossbar output and a peripheral. It forwards one read at a time and registers the response. If the peripheral fails to accept AR or return R within a bounded time, it completes the read upstream with SLVERR so the crossbar's issue accounting never hangs. Late peripheral responses are absorbed and discarded.

---
 rtl/taxi_axil_rd_timeout_if.sv | 32 +++
 rtl/taxi_axil_rd_timeout.sv | 117 +++++++++++
 tb/tb_taxi_axil_rd_timeout.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/taxi_axil_rd_timeout_if.sv
// taxi_axil_if: AXI4-lite read channel bundle with slave and master modports
interface taxi_axil_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter bit ARUSER_EN = 1'b0,
  parameter int ARUSER_W = 1,
  parameter bit RUSER_EN = 1'b0,
  parameter int RUSER_W = 1
);
  logic [ADDR_W-1:0] araddr;
  logic [2:0] arprot;
  logic [ARUSER_W-1:0] aruser;
  logic arvalid;
  logic arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0] rresp;
  logic [RUSER_W-1:0] ruser;
  logic rvalid;
  logic rready;
  modport rd_slv (
    input araddr, arprot, aruser, arvalid,
    output arready,
    output rdata, rresp, ruser, rvalid,
    input rready
  );
  modport rd_mst (
    output araddr, arprot, aruser, arvalid,
    input arready,
    input rdata, rresp, ruser, rvalid,
    output rready
  );
endinterface

// File: rtl/taxi_axil_rd_timeout.sv
// taxi_axil_rd_timeout: AXI-lite read watchdog that answers SLVERR on a stalled peripheral (option: TAXI_AXIL_RD_TIMEOUT_STAT_EN adds timeout_count)
module taxi_axil_rd_timeout #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter logic [511:0] ERR_DATA = '0
) (
  input logic clk,
  input logic rst_n,
  taxi_axil_if.rd_slv s_axil_rd,
  taxi_axil_if.rd_mst m_axil_rd,
  output logic busy,
  output logic timeout_evt
`ifdef TAXI_AXIL_RD_TIMEOUT_STAT_EN
  ,
  output logic [15:0] timeout_count
`endif
);
  localparam int DATA_W = s_axil_rd.DATA_W;
  localparam int ADDR_W = s_axil_rd.ADDR_W;
  localparam bit ARUSER_EN = s_axil_rd.ARUSER_EN && m_axil_rd.ARUSER_EN;
  localparam bit RUSER_EN = s_axil_rd.RUSER_EN && m_axil_rd.RUSER_EN;
  localparam int M_ARUSER_W = m_axil_rd.ARUSER_W;
  localparam int S_RUSER_W = s_axil_rd.RUSER_W;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  if (s_axil_rd.DATA_W != m_axil_rd.DATA_W || s_axil_rd.ADDR_W != m_axil_rd.ADDR_W) begin : g_bad_width
    $error("taxi_axil_rd_timeout: s and m interface widths differ");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("taxi_axil_rd_timeout: TIMEOUT_CYCLES must be at least 2");
  end
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, ERR, ORPH_AR, ORPH_R} state_t;
  state_t state, state_next;
  logic [CNT_W-1:0] cnt;
  logic ar_pend;
  logic [ADDR_W-1:0] araddr_q;
  logic [2:0] arprot_q;
  logic [M_ARUSER_W-1:0] aruser_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0] rresp_q;
  logic [S_RUSER_W-1:0] ruser_q;
  logic s_ar_hs, m_ar_hs, m_r_hs, counting, to_hit;
  assign s_ar_hs = s_axil_rd.arvalid && s_axil_rd.arready;
  assign m_ar_hs = m_axil_rd.arvalid && m_axil_rd.arready;
  assign m_r_hs = m_axil_rd.rvalid && m_axil_rd.rready;
  assign counting = state == ISSUE || state == WAIT;
  assign to_hit = counting && cnt == CNT_W'(TIMEOUT_CYCLES - 1) && !m_r_hs;
  assign s_axil_rd.arready = state == IDLE && rst_n;
  assign s_axil_rd.rvalid = state == RESP || state == ERR;
  assign s_axil_rd.rdata = rdata_q;
  assign s_axil_rd.rresp = rresp_q;
  assign s_axil_rd.ruser = RUSER_EN ? ruser_q : '0;
  assign m_axil_rd.arvalid = state == ISSUE || state == ORPH_AR || (state == ERR && ar_pend);
  assign m_axil_rd.araddr = araddr_q;
  assign m_axil_rd.arprot = arprot_q;
  assign m_axil_rd.aruser = ARUSER_EN ? aruser_q : '0;
  assign m_axil_rd.rready = state == WAIT || state == ORPH_R;
  assign busy = state != IDLE;
  assign timeout_evt = to_hit;
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  end
  // next-state: a timeout beats a late AR accept but loses to a real R beat
  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = s_ar_hs ? ISSUE : IDLE;
      ISSUE: state_next = to_hit ? ERR : m_axil_rd.arready ? WAIT : ISSUE;
      WAIT: state_next = m_axil_rd.rvalid ? RESP : to_hit ? ERR : WAIT;
      RESP: state_next = s_axil_rd.rready ? IDLE : RESP;
      ERR: state_next = !s_axil_rd.rready ? ERR : (ar_pend && !m_axil_rd.arready) ? ORPH_AR : ORPH_R;
      ORPH_AR: state_next = m_axil_rd.arready ? ORPH_R : ORPH_AR;
      ORPH_R: state_next = m_axil_rd.rvalid ? IDLE : ORPH_R;
      default: state_next = IDLE;
    endcase
  end
  // request latch, saturating watchdog counter, response register and pending-AR flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      ar_pend <= 1'b0;
      araddr_q <= '0;
      arprot_q <= '0;
      aruser_q <= '0;
      rdata_q <= '0;
      rresp_q <= '0;
      ruser_q <= '0;
    end else begin
      if (s_ar_hs) begin
        araddr_q <= s_axil_rd.araddr;
        arprot_q <= s_axil_rd.arprot;
        aruser_q <= M_ARUSER_W'(s_axil_rd.aruser);
        cnt <= '0;
      end else if (counting && cnt != CNT_W'(TIMEOUT_CYCLES)) begin
        cnt <= cnt + 1'b1;
      end
      if (state == WAIT && m_axil_rd.rvalid) begin
        rdata_q <= m_axil_rd.rdata;
        rresp_q <= m_axil_rd.rresp;
        ruser_q <= S_RUSER_W'(m_axil_rd.ruser);
      end else if (to_hit) begin
        rdata_q <= ERR_DATA[DATA_W-1:0];
        rresp_q <= 2'b10;
        ruser_q <= '0;
      end
      if (to_hit) ar_pend <= state == ISSUE && !m_axil_rd.arready;
      else if (m_ar_hs) ar_pend <= 1'b0;
    end
  end
`ifdef TAXI_AXIL_RD_TIMEOUT_STAT_EN
  // saturating count of fired timeouts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timeout_count <= '0;
    else if (to_hit && timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_taxi_axil_rd_timeout.sv
// tb_taxi_axil_rd_timeout: directed scoreboard bench for the AXI-lite read watchdog
module tb_taxi_axil_rd_timeout;
  localparam int TO = 16;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic busy, timeout_evt;
`ifdef TAXI_AXIL_RD_TIMEOUT_STAT_EN
  logic [15:0] timeout_count;
`endif
  taxi_axil_if #(.DATA_W(32), .ADDR_W(32)) s_if ();
  taxi_axil_if #(.DATA_W(32), .ADDR_W(32)) m_if ();
  taxi_axil_rd_timeout #(.TIMEOUT_CYCLES(TO), .ERR_DATA(512'(ERRD))) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_axil_rd(s_if),
    .m_axil_rd(m_if),
    .busy(busy),
    .timeout_evt(timeout_evt)
`ifdef TAXI_AXIL_RD_TIMEOUT_STAT_EN
    ,
    .timeout_count(timeout_count)
`endif
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, errors = 0;
  logic [33:0] sb[$];
  int evt_n = 0, evt_cyc = 0, acc_cyc = 0;
  int ar_delay = 0, r_delay = 0, ar_wait = 0, r_wait = 0, r_beats = 0;
  logic [31:0] p_data = '0, seen_addr = '0;
  bit ar_hs = 0, r_hs = 0, r_pend = 0, ar_up = 0;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // upstream monitor: pops the scoreboard on every delivered beat, logs timeout pulses
  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n && timeout_evt) begin
      evt_n++;
      evt_cyc = cyc;
    end
    if (rst_n && s_if.rvalid && s_if.rready) begin
      check("beat_expected", 64'(sb.size() > 0), 1);
      if (sb.size() > 0) check("rbeat", {s_if.rresp, s_if.rdata}, sb.pop_front());
    end
  end
  // peripheral model: AR accepted after ar_delay cycles, R returned r_delay cycles later
  initial begin
    m_if.arready = 0;
    m_if.rvalid = 0;
    m_if.rdata = '0;
    m_if.rresp = '0;
    m_if.ruser = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_if.arready = 0;
        m_if.rvalid = 0;
        ar_hs = 0;
        r_hs = 0;
        r_pend = 0;
        ar_wait = 0;
        ar_up = 0;
      end else begin
        if (ar_up) check("arvalid_held", m_if.arvalid, 1);
        if (ar_hs) begin
          m_if.arready = 0;
          r_pend = 1;
          r_wait = 0;
          ar_wait = 0;
        end
        if (r_hs) begin
          m_if.rvalid = 0;
          r_beats++;
        end
        if (r_pend && !m_if.rvalid) begin
          if (r_wait >= r_delay) begin
            m_if.rvalid = 1;
            m_if.rdata = p_data;
            m_if.rresp = 2'b00;
            r_pend = 0;
          end else r_wait++;
        end
        if (m_if.arvalid && !m_if.arready) begin
          if (ar_wait >= ar_delay) m_if.arready = 1;
          else ar_wait++;
        end
      end
      #1;
      ar_hs = m_if.arvalid && m_if.arready;
      r_hs = m_if.rvalid && m_if.rready;
      ar_up = m_if.arvalid && !m_if.arready;
      if (ar_hs) seen_addr = m_if.araddr;
    end
  end
  task automatic do_read(input logic [31:0] addr, input logic [31:0] pd, input int ard, input int rd,
                         input logic [31:0] ed, input logic [1:0] er, input int eto);
    int n0, b0;
    bit ok;
    ar_delay = ard;
    r_delay = rd;
    p_data = pd;
    n0 = evt_n;
    b0 = r_beats;
    sb.push_back({er, ed});
    @(negedge clk);
    s_if.araddr = addr;
    s_if.arvalid = 1;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      ok = s_if.arready;
      if (ok) break;
      @(negedge clk);
    end
    check("ar_accept", 64'(ok), 1);
    @(negedge clk);
    acc_cyc = cyc;
    s_if.arvalid = 0;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #3;
      if (!busy && sb.size() == 0) begin
        ok = 1;
        break;
      end
    end
    check("drain", 64'(ok), 1);
    check("m_araddr", seen_addr, addr);
    check("timeout_pulses", 64'(evt_n - n0), 64'(eto));
    if (eto > 0) check("timeout_latency", 64'(evt_cyc - acc_cyc), TO - 1);
    check("m_r_beats", 64'(r_beats - b0), 1);
    check("arready_idle", s_if.arready, 1);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    s_if.arvalid = 0;
    s_if.araddr = '0;
    s_if.arprot = '0;
    s_if.aruser = '0;
    s_if.rready = 1;
    #1;
    rst_n = 0;
    repeat (2) @(negedge clk);
    check("rst_arready", s_if.arready, 0);
    check("rst_busy", busy, 0);
    check("rst_s_rvalid", s_if.rvalid, 0);
    check("rst_m_arvalid", m_if.arvalid, 0);
    check("rst_m_rready", m_if.rready, 0);
    check("rst_timeout_evt", timeout_evt, 0);
    rst_n = 1;
    #1;
    check("post_rst_arready", s_if.arready, 1);
    do_read(32'h10, 32'h1234_5678, 0, 3, 32'h1234_5678, 2'b00, 0);
    do_read(32'h14, 32'h55AA_55AA, 40, 0, ERRD, 2'b10, 1);
    do_read(32'h18, 32'h0BAD_0BAD, 0, 30, ERRD, 2'b10, 1);
    do_read(32'h20, 32'h2020_2020, 0, 0, 32'h2020_2020, 2'b00, 0);
    do_read(32'h24, 32'hCAFE_F00D, 0, 14, 32'hCAFE_F00D, 2'b00, 0);
    do_read(32'h28, 32'h2828_2828, 0, 15, ERRD, 2'b10, 1);
    ar_delay = 0;
    r_delay = 200;
    @(negedge clk);
    s_if.araddr = 32'h30;
    s_if.arvalid = 1;
    @(negedge clk);
    s_if.arvalid = 0;
    repeat (5) @(negedge clk);
    check("wait_busy", busy, 1);
    check("wait_m_rready", m_if.rready, 1);
    @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    check("arst_s_rvalid", s_if.rvalid, 0);
    check("arst_m_arvalid", m_if.arvalid, 0);
    check("arst_m_rready", m_if.rready, 0);
    check("arst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    sb.delete();
    #1;
    check("arst_arready", s_if.arready, 1);
    do_read(32'h34, 32'h3434_3434, 0, 2, 32'h3434_3434, 2'b00, 0);
`ifdef TAXI_AXIL_RD_TIMEOUT_STAT_EN
    check("stat_zero", timeout_count, 0);
`endif
    for (int k = 0; k < 3; k++) do_read(32'h40 + 32'(k * 4), 32'h0, 0, 30, ERRD, 2'b10, 1);
`ifdef TAXI_AXIL_RD_TIMEOUT_STAT_EN
    check("stat_three", timeout_count, 3);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
